// File: rtl/matrix_mac3x3_if.sv
// Operand/result stream between the RAM path, the address controller and the 3x3 MAC engine.
// The master side is the controller/RAM; the slave side is the compute engine.
interface matrix_mac3x3_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [DATA_W-1:0] din;
    logic              ready;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] dout;

    modport master (
        output start,
        output din,
        input  ready,
        input  busy,
        input  done,
        input  dout
    );

    modport slave (
        input  start,
        input  din,
        output ready,
        output busy,
        output done,
        output dout
    );
endinterface

// File: rtl/matrix_mac3x3.sv
// 3x3 signed matrix product C = A x B on one shared MAC: 18 LOAD, 27 COMPUTE, 9 WRITE cycles.
// No backpressure: the controller paces din/dout from ready/done. SATURATE_MAC_EN clamps results.
module matrix_mac3x3 #(
    parameter int DATA_W = 32
) (
    input  logic             clk,
    input  logic             clr,
    matrix_mac3x3_if.slave   bus
);
    localparam int ACC_W = 2*DATA_W + 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        WRITE   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [4:0]              cnt;
    logic [1:0]              i_idx, j_idx, k_idx;
    logic signed [ACC_W-1:0] acc;
    logic [DATA_W-1:0]       mat_a [9];
    logic [DATA_W-1:0]       mat_b [9];
    logic [DATA_W-1:0]       mat_c [9];

    logic [3:0]                 a_idx, b_idx, c_idx, ld_b_idx;
    logic signed [2*DATA_W-1:0] op_a, op_b, prod;
    logic signed [ACC_W-1:0]    acc_base, acc_sum;
    logic [DATA_W-1:0]          c_val;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start)      state_nxt = LOAD;
            LOAD:    if (cnt == 5'd17)   state_nxt = COMPUTE;
            COMPUTE: if (cnt == 5'd26)   state_nxt = WRITE;
            WRITE:   if (cnt == 5'd8)    state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    assign bus.ready = (state == LOAD);
    assign bus.busy  = (state == COMPUTE);
    assign bus.done  = (state == WRITE);
    assign bus.dout  = (state == WRITE) ? mat_c[cnt[3:0]] : '0;

    // Element e = 3i+j is reduced over k; i/j/k track cnt so no divide-by-3 is needed.
    assign a_idx    = 4'(i_idx) * 4'd3 + 4'(k_idx);
    assign b_idx    = 4'(k_idx) * 4'd3 + 4'(j_idx);
    assign c_idx    = 4'(i_idx) * 4'd3 + 4'(j_idx);
    assign ld_b_idx = 4'(cnt - 5'd9);

    assign op_a     = {{DATA_W{mat_a[a_idx][DATA_W-1]}}, mat_a[a_idx]};
    assign op_b     = {{DATA_W{mat_b[b_idx][DATA_W-1]}}, mat_b[b_idx]};
    assign prod     = op_a * op_b;
    assign acc_base = (k_idx == 2'd0) ? '0 : acc;
    assign acc_sum  = acc_base + {{2{prod[2*DATA_W-1]}}, prod};

`ifdef SATURATE_MAC_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    always_comb begin
        c_val = acc_sum[DATA_W-1:0];
        if (acc_sum > SAT_MAX)      c_val = {1'b0, {(DATA_W-1){1'b1}}};
        else if (acc_sum < SAT_MIN) c_val = {1'b1, {(DATA_W-1){1'b0}}};
    end
`else
    assign c_val = acc_sum[DATA_W-1:0];
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt   <= '0;
            i_idx <= '0;
            j_idx <= '0;
            k_idx <= '0;
            acc   <= '0;
            for (int n = 0; n < 9; n++) begin
                mat_a[n] <= '0;
                mat_b[n] <= '0;
                mat_c[n] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                end
                LOAD: begin
                    if (cnt < 5'd9) mat_a[cnt[3:0]] <= bus.din;
                    else            mat_b[ld_b_idx] <= bus.din;
                    if (cnt == 5'd17) begin
                        cnt   <= '0;
                        acc   <= '0;
                        i_idx <= '0;
                        j_idx <= '0;
                        k_idx <= '0;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                COMPUTE: begin
                    acc <= acc_sum;
                    if (k_idx == 2'd2) begin
                        mat_c[c_idx] <= c_val;
                        k_idx        <= '0;
                        if (j_idx == 2'd2) begin
                            j_idx <= '0;
                            i_idx <= i_idx + 2'd1;
                        end else begin
                            j_idx <= j_idx + 2'd1;
                        end
                    end else begin
                        k_idx <= k_idx + 2'd1;
                    end
                    cnt <= (cnt == 5'd26) ? 5'd0 : cnt + 5'd1;
                end
                WRITE: begin
                    cnt <= (cnt == 5'd8) ? 5'd0 : cnt + 5'd1;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: doc/matrix_mac3x3.md
Name: matrix_mac3x3

Overview:
- Compute engine for the 3x3 matrix product C = A x B. It sits between the single-port RAM read path and the RAM write path, paced by the address controller.
- Consumes 18 operand words streamed from RAM: A row-major, then B row-major.
- Computes the 9 result elements with one shared multiply-accumulate unit.
- Streams the 9 results back, row-major, on the RAM data input.
- Its ready/busy/done outputs drive the controller's input-PC advance, status, and output-PC advance / write-enable.

Parameters:
- DATA_W, 32, width of operand and result words. Arithmetic is two's-complement signed.

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  asynchronous, active-high reset.
- start  in  1  begin an operation; sampled only in IDLE.
- din  in  DATA_W  operand word from RAM (combinational read of the current address).
- ready  out  1  high during LOAD; din is captured on every rising edge while ready=1.
- busy  out  1  high during COMPUTE.
- done  out  1  high during WRITE; dout is valid and is written to RAM on every edge while done=1.
- dout  out  DATA_W  result word; 0 outside WRITE.

Behaviour:
- Reset (clr=1, asynchronous):
  - state=IDLE, cnt=0, accumulator=0, A/B/C storage=0.
  - ready=busy=done=0, dout=0.
  - Reset mid-operation aborts immediately; no partial results are emitted afterwards.
- Outputs ready/busy/done are pure decodes of the registered state; no combinational path from start.
- IDLE:
  - start=1 at an edge -> LOAD, cnt=0.
  - start=0 -> remain in IDLE.
- LOAD (18 cycles):
  - Each edge: word[cnt] <= din, where cnt 0..8 fills A[0..8] and cnt 9..17 fills B[0..8].
  - cnt increments each edge.
  - Edge that captures cnt=17 -> COMPUTE, cnt=0, accumulator=0.
- COMPUTE (27 cycles):
  - cnt 0..26 decomposes as element e = cnt/3 (i = e/3, j = e%3) and k = cnt%3.
  - Each edge: acc <= (k==0 ? 0 : acc) + A[3i+k]*B[3k+j].
  - When k==2, C[e] <= truncated result (acc + current product).
  - Edge at cnt=26 -> WRITE, cnt=0.
- WRITE (9 cycles):
  - dout = C[cnt] (combinational mux from registered C); done=1.
  - cnt increments each edge.
  - Edge at cnt=8 -> IDLE, cnt=0.
- Latency: start edge -> ready for 18 cycles -> busy for 27 -> done for 9. The first result is on dout 45 cycles after the start edge. A new start is accepted on the first IDLE cycle.
- Arithmetic:
  - Products computed at 2*DATA_W bits.
  - Accumulator is 2*DATA_W+2 bits and never overflows internally.
  - The stored result is the low DATA_W bits (wrap modulo 2^DATA_W) unless SATURATE_MAC_EN is defined.
- start while not in IDLE: ignored, with no effect on state, counters or data.
- din is don't-care outside LOAD.
- Register contents persist after WRITE until the next LOAD overwrites them.

Optional Feature:
- Macro SATURATE_MAC_EN.
- Defined: each C[e] is clamped to the signed DATA_W range. Values above 2^(DATA_W-1)-1 become 0x7FF..F; values below -2^(DATA_W-1) become 0x800..0.
- Undefined: plain wrap-around truncation to the low DATA_W bits.
- Timing and handshake are identical in both builds.

Test Plan:
- Identity: A=I, B={1..9} -> done asserted exactly 9 cycles; dout sequence 1,2,3,4,5,6,7,8,9.
- Constant fill: A all 2, B all 3 -> all nine results = 18 (0x00000012). Cycle counts: ready=18, busy=27, done=9; first dout 45 cycles after the start edge.
- Signed: A = diag(-1,-1,-1) (0xFFFFFFFF), B={1..9} -> results -1..-9, i.e. 0xFFFFFFFF down to 0xFFFFFFF7.
- Overflow: A[0]=0x7FFFFFFF, B[0]=2, all others 0 -> C[0]=0xFFFFFFFE without SATURATE_MAC_EN, 0x7FFFFFFF with it; remaining results 0.
- Reset mid-COMPUTE: assert clr at COMPUTE cycle 10 -> outputs 0 the same cycle, state IDLE. A fresh start with identity/constant data then gives correct results with no stale values.
- start pulsed during LOAD, COMPUTE and WRITE -> ignored. Exactly one 18/27/9 sequence per accepted start; start held high continuously -> back-to-back operations, each beginning on its IDLE cycle.
